// File: rtl/mul_div_unit.sv
// HI/LO multiply-divide unit: fixed-latency multiplier and a radix-2 restoring divider
// that share one operand capture path and a three-state controller.
module mul_div_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   localparam int CNT_MAX = (WIDTH > MULT_CYCLES) ? WIDTH : MULT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t             state;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [WIDTH-1:0]   rem_reg;
   logic [CW-1:0]      cnt;
   logic               mul_signed;
   logic               q_neg;
   logic               r_neg;

   // Operand magnitudes for the divider; the most-negative value maps to 2^(WIDTH-1),
   // which still fits unsigned, so MIN/-1 falls out of the normal sign fix-up.
   logic               div_signed;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;

   assign div_signed = (op == OP_DIV);
   assign a_mag      = (div_signed && A[WIDTH-1]) ? (-A) : A;
   assign b_mag      = (div_signed && B[WIDTH-1]) ? (-B) : B;

   logic [2*WIDTH-1:0] a_ext;
   logic [2*WIDTH-1:0] b_ext;
   logic [2*WIDTH-1:0] product;

   assign a_ext   = mul_signed ? {{WIDTH{a_reg[WIDTH-1]}}, a_reg} : {{WIDTH{1'b0}}, a_reg};
   assign b_ext   = mul_signed ? {{WIDTH{b_reg[WIDTH-1]}}, b_reg} : {{WIDTH{1'b0}}, b_reg};
   assign product = a_ext * b_ext;

   // One restoring step: a_reg shifts the dividend out and the quotient in.
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     rem_sub;
   logic               q_bit;
   logic [WIDTH-1:0]   rem_next;
   logic [WIDTH-1:0]   quot_next;
   logic [WIDTH-1:0]   quot_out;
   logic [WIDTH-1:0]   rem_out;

   assign rem_shift = {rem_reg, a_reg[WIDTH-1]};
   assign rem_sub   = rem_shift - {1'b0, b_reg};
   assign q_bit     = ~rem_sub[WIDTH];
   assign rem_next  = q_bit ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
   assign quot_next = {a_reg[WIDTH-2:0], q_bit};
   assign quot_out  = q_neg ? (-quot_next) : quot_next;
   assign rem_out   = r_neg ? (-rem_next) : rem_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         a_reg      <= '0;
         b_reg      <= '0;
         rem_reg    <= '0;
         cnt        <= '0;
         mul_signed <= 1'b0;
         q_neg      <= 1'b0;
         r_neg      <= 1'b0;
         hi         <= '0;
         lo         <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  case (op)
                     OP_MULT, OP_MULTU: begin
                        a_reg      <= A;
                        b_reg      <= B;
                        mul_signed <= (op == OP_MULT);
                        cnt        <= CW'(MULT_CYCLES - 1);
                        state      <= MUL;
                        busy       <= 1'b1;
                     end
                     OP_DIV, OP_DIVU: begin
                        if (B != '0) begin
                           a_reg   <= a_mag;
                           b_reg   <= b_mag;
                           rem_reg <= '0;
                           q_neg   <= div_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                           r_neg   <= div_signed && A[WIDTH-1];
                           cnt     <= CW'(WIDTH - 1);
                           state   <= DIV;
                           busy    <= 1'b1;
                        end
                     end
                     OP_MTHI: hi <= A;
                     OP_MTLO: lo <= A;
                     default: ;
                  endcase
               end
            end
            MUL: begin
               if (cnt == '0) begin
                  {hi, lo} <= product;
                  state    <= IDLE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DIV: begin
               a_reg   <= quot_next;
               rem_reg <= rem_next;
               if (cnt == '0) begin
                  lo    <= quot_out;
                  hi    <= rem_out;
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit (WIDTH=32, MULT_CYCLES=5) with hand-computed results.
module tb_mul_div_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [2:0]    op;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;
   logic          busy;
   logic          done;

   int n_cmp = 0;
   int n_err = 0;

   mul_div_unit #(.WIDTH(32), .MULT_CYCLES(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .A     (A),
      .B     (B),
      .hi    (hi),
      .lo    (lo),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   // Issues one multi-cycle op, scrambles A/B after capture, and checks latency,
   // HI/LO hold during busy, the result, and the single-cycle done pulse.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int exp_lat,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
      logic [W-1:0] h0, l0;
      int lat;
      bit held;
      @(negedge clk);
      op = o; A = a; B = b; start = 1'b1;
      h0 = hi; l0 = lo;
      @(posedge clk); #1;
      start = 1'b0; A = $urandom; B = $urandom;
      chk({tag, " busy_after_accept"}, 64'(busy), 64'd1);
      lat = 0; held = 1'b1;
      while (!done && lat < 200) begin
         if (hi !== h0 || lo !== l0) held = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, " hilo_held"}, 64'(held), 64'd1);
      chk({tag, " hi"}, 64'(hi), 64'(exp_hi));
      chk({tag, " lo"}, 64'(lo), 64'(exp_lo));
      chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
      @(posedge clk); #1;
      chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
   endtask

   task automatic one_edge(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      op = o; A = a; B = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   initial begin
      logic [W-1:0] h0, l0;
      int lat;
      bit seen_dead, seen_done;

      rst_n = 1'b1; start = 1'b0; op = 3'b000; A = '0; B = '0;
      #1 rst_n = 1'b0;
      #2;
      chk("reset hi", 64'(hi), 64'd0);
      chk("reset lo", 64'(lo), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // MTHI / MTLO: one edge each, never busy
      one_edge(3'b100, 32'h1234_5678, 32'h0);
      chk("mthi hi", 64'(hi), 64'h1234_5678);
      chk("mthi busy", 64'(busy), 64'd0);
      chk("mthi done", 64'(done), 64'd0);
      one_edge(3'b101, 32'h9ABC_DEF0, 32'h0);
      chk("mtlo lo", 64'(lo), 64'h9ABC_DEF0);
      chk("mtlo hi_kept", 64'(hi), 64'h1234_5678);
      chk("mtlo busy", 64'(busy), 64'd0);

      run_op("mult -2*3",    3'b000, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("multu",        3'b001, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
      run_op("mult -1*-1",   3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'h0, 32'h1);
      run_op("div -7/2",     3'b010, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu 7/2",     3'b011, 32'd7, 32'd2, 32, 32'd1, 32'd3);
      run_op("div 7/-2",     3'b010, 32'd7, 32'hFFFF_FFFE, 32, 32'd1, 32'hFFFF_FFFD);
      run_op("divu big",     3'b011, 32'hFFFF_FFFF, 32'h0001_0000, 32, 32'h0000_FFFF, 32'h0000_FFFF);
      run_op("div min/-1",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'h0, 32'h8000_0000);

      // divide by zero is a no-op
      h0 = hi; l0 = lo;
      one_edge(3'b011, 32'd5, 32'd0);
      chk("divu/0 busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      chk("divu/0 done", 64'(done), 64'd0);
      chk("divu/0 hi", 64'(hi), 64'(h0));
      chk("divu/0 lo", 64'(lo), 64'(l0));

      // reserved op leaves everything alone
      one_edge(3'b110, 32'hAAAA_5555, 32'd1);
      chk("rsvd busy", 64'(busy), 64'd0);
      chk("rsvd hi", 64'(hi), 64'(h0));
      chk("rsvd lo", 64'(lo), 64'(l0));

      // MULTU 2*3 with MTHI and DIVU requests arriving while busy
      one_edge(3'b001, 32'd2, 32'd3);
      chk("ovl busy", 64'(busy), 64'd1);
      one_edge(3'b100, 32'h0000_DEAD, 32'd0);
      seen_dead = (hi === 32'h0000_DEAD);
      one_edge(3'b011, 32'd100, 32'd7);
      lat = 2;
      while (!done && lat < 200) begin
         if (hi === 32'h0000_DEAD) seen_dead = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      chk("ovl latency", 64'(lat), 64'd5);
      chk("ovl mthi_ignored", 64'(seen_dead), 64'd0);
      chk("ovl hi", 64'(hi), 64'd0);
      chk("ovl lo", 64'(lo), 64'd6);
      @(posedge clk); #1;
      chk("ovl divu_ignored", 64'(busy), 64'd0);

      // reset mid-divide
      one_edge(3'b011, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst hi", 64'(hi), 64'd0);
      chk("midrst lo", 64'(lo), 64'd0);
      chk("midrst busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      op = 3'b101; A = 32'h0000_0055; B = '0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("postrst first_edge_mtlo", 64'(lo), 64'h55);
      seen_done = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done || busy) seen_done = 1'b1;
      end
      chk("postrst no_done", 64'(seen_done), 64'd0);
      chk("postrst hi", 64'(hi), 64'd0);
      chk("postrst lo", 64'(lo), 64'h55);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
